// File: rtl/ps2_rx_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx_decoder_if                                                    |
// | Key-event output stream: registered head word with valid/ready.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ps2_rx_decoder_if;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/ps2_rx_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx_decoder                                                       |
// | PS/2 device-to-host receiver: filters the clock, decodes frames,     |
// | folds E0/F0 prefixes into 10-bit events, queues them in a FWFT FIFO. |
// | Optional macro PS2_RX_ERR_CNT_EN adds a saturating err_count port.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_rx_decoder #(
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic             CLOCK_50,
    input  wire logic             reset,
    input  wire logic             PS2_CLK,
    input  wire logic             PS2_DAT,
    ps2_rx_decoder_if.master      ev_if,
    output logic                  frame_err,
    output logic                  overflow
`ifdef PS2_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic [1:0]    state_q, state_d;
    logic [10:0]   shreg_q, shreg_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [9:0]    ev_data_q, ev_data_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic       w_clk_s, w_dat_s, w_flip, w_fall, w_timeout, w_ok;
    logic       w_push, w_push_ok, w_pop, w_empty, w_full;
    logic [7:0] w_byte;
    logic [9:0] w_push_data;
    logic [AW:0] w_count;

    assign w_clk_s = clk_s_q[1];
    assign w_dat_s = dat_s_q[1];
    // Filtered clock flips on the FILTER_CYCLES-th consecutive differing sample
    assign w_flip  = (w_clk_s != filt_q) && (fcnt_q == FW'(FILTER_CYCLES - 1));
    assign w_fall  = w_flip && filt_q;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s_q     <= 2'b11;
            dat_s_q     <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            timer_q     <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ev_data_q   <= '0;
        end else begin
            clk_s_q     <= {clk_s_q[0], PS2_CLK};
            dat_s_q     <= {dat_s_q[0], PS2_DAT};
            filt_q      <= w_flip ? ~filt_q : filt_q;
            fcnt_q      <= (w_clk_s == filt_q || w_flip) ? '0 : fcnt_q + FW'(1);
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            timer_q     <= timer_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ev_data_q   <= ev_data_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push_ok) mem_q[wptr_q[AW-1:0]] <= w_push_data;
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: begin
                if (w_fall && !w_dat_s) begin
                    state_d  = S_SHIFT;
                    shreg_d  = {w_dat_s, shreg_q[10:1]};
                    bitcnt_d = 4'd1;
                    timer_d  = '0;
                end
            end
            S_SHIFT: begin
                if (w_fall) begin
                    shreg_d  = {w_dat_s, shreg_q[10:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    timer_d  = '0;
                    if (bitcnt_q == 4'd10) state_d = S_CHECK;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: frame check, prefix folding, error pulse
    assign w_byte      = shreg_q[8:1];
    assign w_ok        = !shreg_q[0] && shreg_q[10] && (^shreg_q[9:1]);
    assign w_timeout   = (state_q == S_SHIFT) && !w_fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign w_push_data = {ext_q, brk_q, w_byte};

    always_comb begin
        w_push      = 1'b0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        frame_err_d = w_timeout;
        if (state_q == S_CHECK) begin
            if (!w_ok) begin
                frame_err_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end else if (w_byte == 8'hE0) begin
                ext_d = 1'b1;
            end else if (w_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                w_push = 1'b1;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    // FIFO: a pop frees a slot in the same cycle, so push-on-full with pop succeeds
    assign w_count   = wptr_q - rptr_q;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = !w_empty && ev_if.ev_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_comb begin
        wptr_d     = wptr_q + (w_push_ok ? (AW+1)'(1) : '0);
        rptr_d     = rptr_q + (w_pop ? (AW+1)'(1) : '0);
        overflow_d = overflow_q | (w_push && w_full && !w_pop);
        ev_data_d  = ev_data_q;
        if (wptr_d != rptr_d) begin
            ev_data_d = (w_push_ok && rptr_d == wptr_q) ? w_push_data
                                                        : mem_q[rptr_d[AW-1:0]];
        end
    end

    assign ev_if.ev_data  = ev_data_q;
    assign ev_if.ev_valid = !w_empty;
    assign frame_err      = frame_err_q;
    assign overflow       = overflow_q;

`ifdef PS2_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            err_cnt_q <= '0;
        else if (frame_err_d && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end
    assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_rx_decoder                                                    |
// | Self-checking bench: vector table, corner sequences, random keys.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ps2_rx_decoder;

    localparam int TMO = 200;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic PS2_CLK  = 1'b1;
    logic PS2_DAT  = 1'b1;
    logic frame_err, overflow;
`ifdef PS2_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    ps2_rx_decoder_if ev_if ();

    ps2_rx_decoder #(.FILTER_CYCLES(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .ev_if    (ev_if.master),
        .frame_err(frame_err),
        .overflow (overflow)
`ifdef PS2_RX_ERR_CNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int errp   = 0;

    always @(posedge CLOCK_50) if (frame_err === 1'b1) errp++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad);
        return {1'b1, (~(^b)) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            repeat (10) @(negedge CLOCK_50);
            PS2_CLK = 1'b0;
            repeat (20) @(negedge CLOCK_50);
            PS2_CLK = 1'b1;
            repeat (10) @(negedge CLOCK_50);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad);
        send_bits(mkframe(b, bad), 11);
        repeat (20) @(negedge CLOCK_50);
    endtask

    task automatic pop_one();
        ev_if.ev_ready = 1'b1;
        @(negedge CLOCK_50);
        ev_if.ev_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       bad;
        logic       exp_ev;
        logic [9:0] exp_data;
        int         exp_err;
    } vec_t;

    vec_t vecs [13];
    logic [9:0] exp_q [$];

    initial begin
        int e0, n;
        logic [9:0] keys [5];
        logic m_ext, m_brk;
        int exp_errs;
        bit done;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
        vecs[3]  = '{8'h75, 1'b0, 1'b1, 10'h375, 0};
        vecs[4]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1};
        vecs[5]  = '{8'h29, 1'b0, 1'b1, 10'h029, 0};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
        vecs[11] = '{8'h12, 1'b0, 1'b1, 10'h212, 0};
        vecs[12] = '{8'h5A, 1'b0, 1'b1, 10'h05A, 0};

        ev_if.ev_ready = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check("reset_valid", {31'd0, ev_if.ev_valid}, 0);
        check("reset_data", {22'd0, ev_if.ev_data}, 0);
        check("reset_ferr", {31'd0, frame_err}, 0);
        check("reset_ovf", {31'd0, overflow}, 0);
`ifdef PS2_RX_ERR_CNT_EN
        check("reset_errcnt", {24'd0, err_count}, 0);
`endif
        reset = 1'b0;
        repeat (20) @(negedge CLOCK_50);

        // First frame: ev_valid 7 cycles after the stop-bit clock edge is driven
        // (2 sync + 4 filter samples + 2-cycle decode latency, less one sample overlap)
        send_bits(mkframe(8'h1C, 1'b0), 10);
        repeat (10) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        n = 0;
        while (!ev_if.ev_valid && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("latency", n, 7);
        check("lat_data", {22'd0, ev_if.ev_data}, 10'h01C);
        repeat (10) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        check("lat_noerr", errp, 0);
        pop_one();

        foreach (vecs[i]) begin
            e0 = errp;
            send_frame(vecs[i].b, vecs[i].bad);
            check($sformatf("vec%0d_valid", i), {31'd0, ev_if.ev_valid}, {31'd0, vecs[i].exp_ev});
            if (vecs[i].exp_ev) begin
                check($sformatf("vec%0d_data", i), {22'd0, ev_if.ev_data}, {22'd0, vecs[i].exp_data});
                pop_one();
            end
            check($sformatf("vec%0d_err", i), errp - e0, vecs[i].exp_err);
        end
`ifdef PS2_RX_ERR_CNT_EN
        check("errcnt", {24'd0, err_count}, errp);
`endif

        // Timeout after 5 bits, then normal decode
        e0 = errp;
        send_bits(mkframe(8'h1C, 1'b0), 5);
        repeat (TMO + 50) @(negedge CLOCK_50);
        check("tmo_err", errp - e0, 1);
        check("tmo_noev", {31'd0, ev_if.ev_valid}, 0);
        send_frame(8'h1C, 1'b0);
        check("tmo_next", {22'd0, ev_if.ev_data}, 10'h01C);
        check("tmo_next_v", {31'd0, ev_if.ev_valid}, 1);
        pop_one();

        // Overflow: five keys into a four-deep FIFO
        keys = '{10'h01C, 10'h029, 10'h016, 10'h075, 10'h05A};
        foreach (keys[i]) send_frame(keys[i][7:0], 1'b0);
        check("ovf_set", {31'd0, overflow}, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_pop%0d", i), {22'd0, ev_if.ev_data}, {22'd0, keys[i]});
            pop_one();
        end
        check("ovf_empty", {31'd0, ev_if.ev_valid}, 0);
        check("ovf_sticky", {31'd0, overflow}, 1);

        // Reset mid-frame
        send_bits(mkframe(8'h1C, 1'b0), 6);
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_data", {22'd0, ev_if.ev_data}, 0);
        reset = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        e0 = errp;
        send_frame(8'h16, 1'b0);
        check("rst_next", {22'd0, ev_if.ev_data}, 10'h016);
        check("rst_noerr", errp - e0, 0);
        pop_one();

        // 3-cycle clock glitch with data low must not start a frame
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        e0 = errp;
        send_frame(8'h1C, 1'b0);
        check("glitch_data", {22'd0, ev_if.ev_data}, 10'h01C);
        check("glitch_noerr", errp - e0, 0);
        pop_one();

        // Random key streams against a prefix-folding model
        m_ext = 0; m_brk = 0; exp_errs = 0; done = 0;
        e0 = errp;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] b;
                    logic bad;
                    int r;
                    r = $urandom_range(0, 9);
                    b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
                    bad = ($urandom_range(0, 9) == 0);
                    if (bad) begin
                        m_ext = 0; m_brk = 0; exp_errs++;
                    end else if (b == 8'hE0) m_ext = 1;
                    else if (b == 8'hF0) m_brk = 1;
                    else begin
                        exp_q.push_back({m_ext, m_brk, b});
                        m_ext = 0; m_brk = 0;
                    end
                    send_frame(b, bad);
                end
                n = 0;
                while (exp_q.size() > 0 && n < 2000) begin
                    @(negedge CLOCK_50);
                    n++;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge CLOCK_50);
                    ev_if.ev_ready = 1'($urandom_range(0, 1));
                    if (ev_if.ev_valid && ev_if.ev_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_extra", {22'd0, ev_if.ev_data}, 32'hFFFF_FFFF);
                        end else begin
                            check("rand_ev", {22'd0, ev_if.ev_data}, {22'd0, exp_q[0]});
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        join
        ev_if.ev_ready = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_errs", errp - e0, exp_errs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
